// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_pkg
// Brief   : Shared BCD conversion constants and FSM encodings.
// Rev     : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int         BCD_DIG_W      = 4;
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_OFFSET = 4'd3;

   localparam logic [1:0] BCD_IDLE  = 2'd0;
   localparam logic [1:0] BCD_SHIFT = 2'd1;
   localparam logic [1:0] BCD_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bcd_convert_seq_adj.sv
`default_nettype none
// ============================================================================
// Module : bcd_digit_adj
// Brief  : Double-dabble digit correction, d>=5 ? d+3 : d (wraps mod 16).
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
   import aes_pkg::*;
(
   input  logic [BCD_DIG_W-1:0] d_in,
   output logic [BCD_DIG_W-1:0] d_out
);

   assign d_out = (d_in >= BCD_ADJ_THRESH) ? d_in + BCD_ADJ_OFFSET : d_in;

endmodule
`default_nettype wire

// File: rtl/bcd_convert_seq.sv
`default_nettype none
// ============================================================================
// Module : bcd_convert_seq
// Brief  : Iterative binary-to-BCD converter, one correct-and-shift per clock.
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_convert_seq
   import aes_pkg::*;
#(
   parameter  int BIN_W  = 8,
   localparam int DIGITS = (BIN_W * 301 + 999) / 1000,
   localparam int CNT_W  = $clog2(BIN_W + 1)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BIN_W-1:0]        bin_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*DIGITS-1:0]     bcd_out,
   output logic [CNT_W-1:0]        nz_digits
);

   localparam int BCD_W = BCD_DIG_W * DIGITS;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [BIN_W-1:0] r_bin;
   logic [BCD_W-1:0] r_bcd;
   logic [BCD_W-1:0] w_bcd_adj;
   logic [CNT_W-1:0] w_nz;
   logic             w_unused_msb;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adj u_adj (
         .d_in  (r_bcd[g*BCD_DIG_W +: BCD_DIG_W]),
         .d_out (w_bcd_adj[g*BCD_DIG_W +: BCD_DIG_W])
      );
   end

   // Top bit of the corrected digits is shifted out; in-range operands keep it zero.
   assign w_unused_msb = w_bcd_adj[BCD_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= BCD_IDLE;
         r_cnt   <= '0;
         r_bin   <= '0;
         r_bcd   <= '0;
      end else begin
         case (r_state)
            BCD_IDLE: begin
               if (in_valid) begin
                  r_bin   <= bin_in;
                  r_bcd   <= '0;
                  r_cnt   <= CNT_W'(BIN_W);
                  r_state <= BCD_SHIFT;
               end
            end
            BCD_SHIFT: begin
               r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_W-1]};
               r_bin <= {r_bin[BIN_W-2:0], 1'b0};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1))
                  r_state <= BCD_DONE;
            end
            BCD_DONE: begin
               if (out_ready)
                  r_state <= BCD_IDLE;
            end
            default: r_state <= BCD_IDLE;
         endcase
      end
   end

   // Leading-digit priority encoder; all-zero still reports one digit.
   always_comb begin
      w_nz = CNT_W'(1);
      for (int i = 1; i < DIGITS; i++) begin
         if (r_bcd[i*BCD_DIG_W +: BCD_DIG_W] != '0)
            w_nz = CNT_W'(i + 1);
      end
   end

   assign in_ready  = (r_state == BCD_IDLE);
   assign out_valid = (r_state == BCD_DONE);
   assign bcd_out   = r_bcd;
   assign nz_digits = w_nz;

endmodule
`default_nettype wire
